// File: rtl/acq_sequencer_if.sv
// Command, sample and transmit-stream signals of the acquisition sequencer.
// The master side issues commands and samples; the slave side is the sequencer.
interface acq_sequencer_if #(
  parameter int DATA_SIZE  = 8,
  parameter int PARAM_SIZE = 4
);
  logic                  i_cmd_reset;
  logic                  i_cmd_sample;
  logic                  i_cmd_decim;
  logic [PARAM_SIZE-1:0] i_param;
  logic [DATA_SIZE-1:0]  i_data;
  logic                  i_data_valid;
  logic [DATA_SIZE-1:0]  o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output i_cmd_reset, i_cmd_sample, i_cmd_decim, i_param,
    output i_data, i_data_valid, i_tx_ready,
    input  o_tx_data, o_tx_valid, o_busy, o_done
  );

  modport slave (
    input  i_cmd_reset, i_cmd_sample, i_cmd_decim, i_param,
    input  i_data, i_data_valid, i_tx_ready,
    output o_tx_data, o_tx_valid, o_busy, o_done
  );
endinterface

// File: rtl/acq_sequencer.sv
// Burst acquisition sequencer: captures N decimated samples into a small buffer,
// then streams them out over a valid/ready interface toward a UART transmitter.
module acq_sequencer #(
  parameter int DATA_SIZE  = 8,
  parameter int PARAM_SIZE = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  acq_sequencer_if.slave    bus
);
  localparam int DEPTH = 2 ** PARAM_SIZE;

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

  state_t                state;
  logic [PARAM_SIZE-1:0] decim_param;
  logic [PARAM_SIZE-1:0] count_param;
  logic [PARAM_SIZE-1:0] decim_cnt;
  logic [PARAM_SIZE-1:0] wr_ptr;
  logic [PARAM_SIZE-1:0] rd_ptr;
  logic                  tx_valid;
  logic                  busy;
  logic                  done;
  logic [DATA_SIZE-1:0]  buffer [DEPTH];
  logic                  sample_take;

  // A sample is kept only on the D-th valid cycle; an abort suppresses the write.
  assign sample_take = (state == CAPTURE) && bus.i_data_valid &&
                       (decim_cnt == decim_param) && !bus.i_cmd_reset;

  always_ff @(posedge i_clock) begin
    if (sample_take) begin
      buffer[wr_ptr] <= bus.i_data;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      decim_param <= '0;
      count_param <= '0;
      decim_cnt   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (bus.i_cmd_reset) begin
      state       <= IDLE;
      decim_param <= '0;
      count_param <= '0;
      decim_cnt   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_cmd_decim) begin
            decim_param <= bus.i_param;
          end
          if (bus.i_cmd_sample) begin
            count_param <= bus.i_param;
            decim_cnt   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            busy        <= 1'b1;
            state       <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (sample_take) begin
            decim_cnt <= '0;
            if (wr_ptr == count_param) begin
              tx_valid <= 1'b1;
              state    <= SEND;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end else if (bus.i_data_valid) begin
            decim_cnt <= decim_cnt + 1'b1;
          end
        end
        SEND: begin
          if (tx_valid && bus.i_tx_ready) begin
            if (rd_ptr == count_param) begin
              rd_ptr   <= '0;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Data is gated by valid so it reads zero whenever nothing is offered, including in reset.
  assign bus.o_tx_data  = tx_valid ? buffer[rd_ptr] : '0;
  assign bus.o_tx_valid = tx_valid;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: a per-cycle vector table for a basic burst,
// then hand-written sequences checked against a scoreboard of transmitted bytes.
module tb_acq_sequencer;
  localparam int DW = 8;
  localparam int PW = 4;

  logic i_clock = 1'b0;
  logic i_reset = 1'b0;

  acq_sequencer_if #(.DATA_SIZE(DW), .PARAM_SIZE(PW)) bus ();

  acq_sequencer #(.DATA_SIZE(DW), .PARAM_SIZE(PW)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic          cmd_reset, cmd_sample, cmd_decim;
    logic [PW-1:0] param;
    logic [DW-1:0] data;
    logic          valid, ready;
    logic          exp_busy, exp_tx_valid;
    logic [DW-1:0] exp_tx_data;
    logic          exp_done;
  } vec_t;

  vec_t          vt [10];
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] sent  [$];
  logic [DW-1:0] exp_q [$];

  // Inputs change just after a rising edge, so at the falling edge they show what the next edge will see.
  always @(negedge i_clock) begin
    if (i_reset && bus.o_tx_valid && bus.i_tx_ready) begin
      sent.push_back(bus.o_tx_data);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic cs, input logic cd, input logic [PW-1:0] p,
                               input logic [DW-1:0] d, input logic v, input logic r);
    bus.i_cmd_reset  = cr;
    bus.i_cmd_sample = cs;
    bus.i_cmd_decim  = cd;
    bus.i_param      = p;
    bus.i_data       = d;
    bus.i_data_valid = v;
    bus.i_tx_ready   = r;
    @(posedge i_clock);
    #1;
  endtask

  task automatic feedSamples(input logic [DW-1:0] first, input int count);
    for (int i = 0; i < count; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, first + DW'(i), 1'b1, 1'b1);
    end
  endtask

  task automatic waitDone(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      if (bus.o_done) seen = 1'b1;
    end
    checkOutput({name, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({name, " busy_after"}, 32'(bus.o_busy), 32'd0);
      checkOutput({name, " txv_after"}, 32'(bus.o_tx_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput({name, " done_one_cycle"}, 32'(bus.o_done), 32'd0);
    end
  endtask

  task automatic checkSent(input string name);
    checkOutput({name, " count"}, 32'(sent.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < sent.size()) begin
        checkOutput($sformatf("%s byte%0d", name, i), 32'(sent[i]), 32'(exp_q[i]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    bus.i_cmd_reset  = 1'b0;
    bus.i_cmd_sample = 1'b0;
    bus.i_cmd_decim  = 1'b0;
    bus.i_param      = '0;
    bus.i_data       = '0;
    bus.i_data_valid = 1'b0;
    bus.i_tx_ready   = 1'b0;

    //        rst   smp   dec   param  data    vld   rdy   busy  txv   txdata  done
    vt[0] = '{1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h13, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h13, 1'b0};
    vt[8] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[9] = '{1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    // Hard reset state, observed before any clock edge.
    #2;
    checkOutput("reset busy", 32'(bus.o_busy), 32'd0);
    checkOutput("reset txv", 32'(bus.o_tx_valid), 32'd0);
    checkOutput("reset txdata", 32'(bus.o_tx_data), 32'd0);
    checkOutput("reset done", 32'(bus.o_done), 32'd0);
    repeat (2) @(posedge i_clock);
    #1;
    i_reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vt[i].cmd_reset, vt[i].cmd_sample, vt[i].cmd_decim, vt[i].param,
                    vt[i].data, vt[i].valid, vt[i].ready);
      checkOutput($sformatf("vec%0d busy", i), 32'(bus.o_busy), 32'(vt[i].exp_busy));
      checkOutput($sformatf("vec%0d txv", i), 32'(bus.o_tx_valid), 32'(vt[i].exp_tx_valid));
      checkOutput($sformatf("vec%0d done", i), 32'(bus.o_done), 32'(vt[i].exp_done));
      if (vt[i].exp_tx_valid) begin
        checkOutput($sformatf("vec%0d txdata", i), 32'(bus.o_tx_data), 32'(vt[i].exp_tx_data));
      end
    end

    // Decimation by 3, burst of 2.
    sent.delete();
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd2, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, '0, 1'b0, 1'b1);
    checkOutput("decim busy", 32'(bus.o_busy), 32'd1);
    feedSamples(8'h01, 6);
    waitDone("decim", 20);
    exp_q = '{8'h03, 8'h06};
    checkSent("decim");

    // Ready toggling 1-0-0-1 while sending.
    sent.delete();
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, '0, 1'b0, 1'b1);
    feedSamples(8'h21, 4);
    checkOutput("stall txv0", 32'(bus.o_tx_valid), 32'd1);
    checkOutput("stall data0", 32'(bus.o_tx_data), 32'h21);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("stall data1", 32'(bus.o_tx_data), 32'h22);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("stall hold1 txv", 32'(bus.o_tx_valid), 32'd1);
    checkOutput("stall hold1 data", 32'(bus.o_tx_data), 32'h22);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("stall hold2 data", 32'(bus.o_tx_data), 32'h22);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("stall data3", 32'(bus.o_tx_data), 32'h23);
    waitDone("stall", 20);
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h24};
    checkSent("stall");

    // Soft abort after 2 of 5 samples with D=2; D must read back as 1 afterwards.
    sent.delete();
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd1, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd4, '0, 1'b0, 1'b1);
    feedSamples(8'h71, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("abort busy", 32'(bus.o_busy), 32'd0);
    checkOutput("abort txv", 32'(bus.o_tx_valid), 32'd0);
    checkOutput("abort done", 32'(bus.o_done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput($sformatf("abort quiet%0d txv", i), 32'(bus.o_tx_valid), 32'd0);
    end
    exp_q = {};
    checkSent("abort");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, '0, 1'b0, 1'b1);
    feedSamples(8'h31, 2);
    waitDone("after_abort", 20);
    exp_q = '{8'h31, 8'h32};
    checkSent("after_abort");

    // Commands issued during capture must not disturb the running burst.
    sent.delete();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd7, 8'h41, 1'b1, 1'b1);
    feedSamples(8'h42, 2);
    waitDone("ignore_cmd", 20);
    exp_q = '{8'h41, 8'h42, 8'h43};
    checkSent("ignore_cmd");

    // Hard reset asserted between clock edges while sending.
    sent.delete();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, '0, 1'b0, 1'b1);
    feedSamples(8'h51, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("async pre txv", 32'(bus.o_tx_valid), 32'd1);
    checkOutput("async pre data", 32'(bus.o_tx_data), 32'h51);
    #2;
    i_reset = 1'b0;
    #1;
    checkOutput("async txv", 32'(bus.o_tx_valid), 32'd0);
    checkOutput("async busy", 32'(bus.o_busy), 32'd0);
    checkOutput("async txdata", 32'(bus.o_tx_data), 32'd0);
    checkOutput("async done", 32'(bus.o_done), 32'd0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    exp_q = {};
    checkSent("async_none");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, '0, 1'b0, 1'b1);
    feedSamples(8'h61, 2);
    waitDone("after_async", 20);
    exp_q = '{8'h61, 8'h62};
    checkSent("after_async");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8: width of sample and transmit data.
REQ-002 SHALL have parameter PARAM_SIZE, default 4: width of command parameter; buffer depth = 2**PARAM_SIZE (16).
REQ-003 SHALL have port i_clock  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port i_cmd_reset  in  1  one-cycle soft-abort command pulse.
REQ-006 SHALL have port i_cmd_sample  in  1  one-cycle start-burst command pulse.
REQ-007 SHALL have port i_cmd_decim  in  1  one-cycle set-decimation command pulse.
REQ-008 SHALL have port i_param  in  PARAM_SIZE  command parameter, valid with any command pulse.
REQ-009 SHALL have port i_data  in  DATA_SIZE  incoming sample.
REQ-010 SHALL have port i_data_valid  in  1  sample qualifier, one sample per high cycle.
REQ-011 SHALL have port o_tx_data  out  DATA_SIZE  stream data toward UART transmitter.
REQ-012 SHALL have port o_tx_valid  out  1  stream valid.
REQ-013 SHALL have port i_tx_ready  in  1  stream ready; transfer when o_tx_valid && i_tx_ready.
REQ-014 SHALL have port o_busy  out  1  high in CAPTURE or SEND.
REQ-015 SHALL have port o_done  out  1  one-cycle pulse on burst completion.

Function
REQ-016 SHALL implement states IDLE, CAPTURE, SEND; o_busy = (state != IDLE), registered.
REQ-017 SHALL hold decimation factor D = stored_param+1 (1..16); i_cmd_decim in IDLE stores i_param; i_cmd_decim outside IDLE ignored.
REQ-018 SHALL, on i_cmd_sample in IDLE at cycle t, store N = i_param+1 (1..16) and be in CAPTURE with o_busy=1 at t+1; i_cmd_sample outside IDLE ignored.
REQ-019 SHALL, when i_cmd_sample and i_cmd_decim coincide in IDLE, apply the new D to the burst being started.
REQ-020 SHALL in CAPTURE count i_data_valid cycles with a decimation counter cleared on entry; when counter == D-1 and i_data_valid, write i_data to buffer at write pointer, clear counter, increment stored count; i_data when i_data_valid=0 ignored.
REQ-021 SHALL with D=1 store every valid sample; first stored sample is the D-th valid sample after entry.
REQ-022 SHALL enter SEND the cycle after the N-th sample is written; no buffer overflow is possible (N <= depth).
REQ-023 SHALL in SEND drive o_tx_valid=1 and o_tx_data=buffer[read pointer], read pointer starting at 0; o_tx_data SHALL be stable while o_tx_valid && !i_tx_ready.
REQ-024 SHALL advance read pointer on each transfer; on the N-th transfer enter IDLE next cycle with o_tx_valid=0 and o_done=1 for exactly that one cycle.
REQ-025 SHALL in IDLE and CAPTURE hold o_tx_valid=0.
REQ-026 SHALL treat i_cmd_reset as highest priority in any state: next cycle state=IDLE, pointers/counters cleared, D reset to 1, o_tx_valid=0, o_done=0; concurrent i_cmd_sample/i_cmd_decim ignored.
REQ-027 SHALL accept that a soft abort in SEND may withdraw o_tx_valid without a transfer.
REQ-028 SHALL not retain buffer contents meaningfully across bursts; buffer need not be reset.

Reset
REQ-029 SHALL, while i_reset=0, immediately force state=IDLE, D=1, N=1, all pointers and counters 0, o_tx_valid=0, o_tx_data=0, o_busy=0, o_done=0.
REQ-030 SHALL resume normal operation on the first rising edge after i_reset returns to 1.

Verification
REQ-031 Bench SHALL cover: sample param=3, D=1, valid every cycle data 0x10..0x13, ready=1 -> CAPTURE 4 cycles, 0x10,0x11,0x12,0x13 sent, o_done one pulse, o_busy low after.
REQ-032 Bench SHALL cover: decim param=2 then sample param=1, data 0x01..0x06 valid -> 0x03,0x06 sent.
REQ-033 Bench SHALL cover: SEND with i_tx_ready toggling 1-0-0-1 -> o_tx_data stable while stalled, no duplicated or lost bytes.
REQ-034 Bench SHALL cover: i_cmd_reset mid-CAPTURE after 2 of 5 samples -> IDLE next cycle, no transmit, D reads back as 1 on next burst.
REQ-035 Bench SHALL cover: i_cmd_sample and i_cmd_decim in CAPTURE -> ignored, burst completes with original N and D.
REQ-036 Bench SHALL cover: i_reset=0 asynchronously mid-SEND -> o_tx_valid, o_busy drop without clock edge; new burst works after release.
